neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Single-neuron compute stage that sits directly downstream of the weight memory.
- Drives the memory's read address.
- Consumes the returned 32-bit weight combinationally in the same cycle.
- Multiplies each streamed activation by its weight and accumulates over NUM_INPUTS terms, then adds a bias, saturates and optionally applies ReLU.
- Presents one 32-bit result per start through a valid/ready output.

Parameters:
- NUM_INPUTS, 784, number of input/weight pairs per neuron; must match the weight memory depth.
- DATA_W, 32, width of activations, weights, bias and result.
- FRAC_W, 16, fractional bits; all values are signed Q15.16.
- ACC_W, 58, accumulator width; must be >= 2*DATA_W-FRAC_W+clog2(NUM_INPUTS), so no overflow is possible.
- BIAS, 32'h0, signed Q15.16 bias added after accumulation.
- RELU, 1, 1 = clamp negative results to 0; 0 = pass signed result.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins a neuron evaluation; honoured only in IDLE.
- in_valid, input, 1, in_data is valid.
- in_data, input, 32, signed Q15.16 activation.
- in_ready, output, 1, block accepts in_data this cycle.
- w_addr, output, 32, read address to weight memory.
- w_data, input, 32, signed Q15.16 weight returned combinationally for w_addr.
- out_valid, output, 1, out_data holds the final result.
- out_data, output, 32, signed Q15.16 neuron output.
- out_ready, input, 1, consumer accepts out_data.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE; idx, acc, out_data, out_valid and in_ready all 0. Reset asserted mid-operation aborts immediately; no partial result is ever emitted.
- State machine:
  - IDLE -> ACCUM on start. idx and acc clear on that edge.
  - ACCUM -> FINAL on the accept with idx==NUM_INPUTS-1.
  - FINAL -> DONE after one cycle.
  - DONE -> IDLE on out_valid&&out_ready.
- in_ready = (state==ACCUM). It is combinational from state only, never from in_valid.
- w_addr = idx, zero-extended, while in ACCUM; 0 otherwise. Weight for element k is read at address k.
- Accept = in_valid&&in_ready. On accept:
  - prod = in_data*w_data as a signed 64-bit product.
  - term = prod>>>FRAC_W (arithmetic shift, truncation toward -inf), sign-extended to ACC_W.
  - acc <= acc+term; idx <= idx+1.
- Gaps in in_valid stall idx and acc; there is no timeout.
- FINAL cycle:
  - sum = acc + sign-extended BIAS.
  - Saturate sum to [32'h80000000, 32'h7FFFFFFF].
  - If RELU, negative values become 0.
  - Register the result into out_data; out_valid rises on the next edge (entering DONE).
- Latency: out_valid is high exactly 2 cycles after the final accept edge.
- DONE: out_data and out_valid hold stable until out_ready. out_valid falls the cycle after the handshake; out_data retains its value.
- start outside IDLE is ignored, including start coincident with the output handshake.
- NUM_INPUTS==1: ACCUM lasts a single accept.
- idx width is clog2(NUM_INPUTS); it never wraps because it resets on start.

Decomposition:
- Shared package nn_pkg holds:
  - DATA_W and FRAC_W constants.
  - Q-format saturation limits SAT_MAX/SAT_MIN.
  - The state enum: IDLE, ACCUM, FINAL, DONE.
  - A clog2 helper.
- One natural sub-module, q_mul: signed DATA_W x DATA_W multiply with arithmetic right-shift by FRAC_W, producing a (2*DATA_W-FRAC_W)-bit result.
- The weight memory is instantiated by the parent layer, not inside this block.

Test Plan:
- Basic sum: NUM_INPUTS=4; weights all 0x00010000; inputs 1.0, 2.0, 3.0, 4.0 (0x00010000..0x00040000); BIAS=0 -> out_data=0x000A0000; out_valid exactly 2 cycles after the 4th accept.
- ReLU: NUM_INPUTS=4; weights -1.0 (0xFFFF0000); inputs 1.0 each. RELU=1 -> out_data=0x00000000. RELU=0 -> 0xFFFC0000.
- Saturation:
  - All weights and inputs 0x7FFFFFFF -> out_data=0x7FFFFFFF.
  - Weights 0x80000000 with inputs 0x7FFFFFFF, RELU=0 -> 0x80000000.
- Full-size truncation with the real memory instance: NUM_INPUTS=784; all weights 0x00008000 (0.5); all inputs 0x00000003; each term truncates to 1 -> out_data=0x00000310.
- Flow control:
  - Random in_valid gaps and out_ready held low 10 cycles give the same result as the basic-sum case.
  - out_data is stable while out_valid&&!out_ready.
  - start pulses during ACCUM and DONE have no effect.
- Reset: assert rst_n=0 after 2 of 4 accepts -> all outputs 0 immediately. Release and rerun the basic-sum case -> 0x000A0000, with no carry-over of acc.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network compute blocks: Q15.16 format
// constants, saturation limits, the neuron state encoding and a clog2 helper.
package nn_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;

  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINAL,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/neuron_mac_q_mul.sv
// Signed Q15.16 multiply: full-precision product arithmetically shifted right
// by FRAC_W, keeping every remaining integer bit so nothing is lost here.
module q_mul
  import nn_pkg::*;
(
  input  logic signed [DATA_W-1:0]          a,
  input  logic signed [DATA_W-1:0]          b,
  output logic signed [2*DATA_W-FRAC_W-1:0] p
);

  localparam int P_W = 2*DATA_W - FRAC_W;

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;

  assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};

  // The shift rounds toward -inf; the dropped top bits are only sign copies
  assign p = P_W'((a_ext * b_ext) >>> FRAC_W);

endmodule

// File: rtl/neuron_mac.sv
// Single neuron: streams activations against weights read from an external
// memory, accumulates, adds bias, saturates, optionally applies ReLU.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int                NUM_INPUTS = 784,
  // Must be >= 2*DATA_W-FRAC_W+clog2(NUM_INPUTS) so the sum can never overflow
  parameter int                ACC_W      = 58,
  parameter logic [DATA_W-1:0] BIAS       = 32'h0,
  parameter bit                RELU       = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  localparam int               IDX_W    = (clog2(NUM_INPUTS) < 1) ? 1 : clog2(NUM_INPUTS);
  localparam int               TERM_W   = 2*DATA_W - FRAC_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [ACC_W-1:0]         acc;
  logic signed [TERM_W-1:0] term;
  logic [ACC_W-1:0]         term_ext;
  logic [ACC_W-1:0]         sum;
  logic [DATA_W-1:0]        result;
  logic                     accept;

  q_mul u_q_mul (
    .a (in_data),
    .b (w_data),
    .p (term)
  );

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign w_addr   = (state == ACCUM) ? {{(DATA_W-IDX_W){1'b0}}, idx} : '0;
  assign term_ext = {{(ACC_W-TERM_W){term[TERM_W-1]}}, term};

  // Result fits when all bits above the Q15.16 sign bit agree with the sign
  always_comb begin
    sum    = acc + {{(ACC_W-DATA_W){BIAS[DATA_W-1]}}, BIAS};
    result = sum[DATA_W-1:0];
    if (sum[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){sum[ACC_W-1]}}) begin
      result = sum[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
    if (RELU && result[DATA_W-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            idx   <= '0;
            acc   <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc + term_ext;
            idx <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state <= FINAL;
            end
          end
        end
        FINAL: begin
          out_data  <= result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: four configurations share the input stream,
// expected results are queued at stimulus time and checked by a monitor.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  busy;
  logic [31:0] w_addr[4];
  logic [31:0] w_data[4];
  logic [31:0] out_data[4];

  logic [31:0] wa[4];
  logic [31:0] wb[4];
  logic [31:0] wc;
  logic [31:0] wd;
  logic [31:0] din[784];

  typedef struct {
    int          dut;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] held[4];
  bit          stalled[4];

  always #5 clk = ~clk;

  assign w_data[0] = wa[w_addr[0][1:0]];
  assign w_data[1] = wb[w_addr[1][1:0]];
  assign w_data[2] = wc;
  assign w_data[3] = wd;

  neuron_mac #(.NUM_INPUTS(4), .RELU(1'b1)) u_relu4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .w_addr(w_addr[0]), .w_data(w_data[0]), .out_valid(out_valid[0]),
    .out_data(out_data[0]), .out_ready(out_ready), .busy(busy[0])
  );

  neuron_mac #(.NUM_INPUTS(4), .RELU(1'b0)) u_lin4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .w_addr(w_addr[1]), .w_data(w_data[1]), .out_valid(out_valid[1]),
    .out_data(out_data[1]), .out_ready(out_ready), .busy(busy[1])
  );

  neuron_mac #(.NUM_INPUTS(784), .RELU(1'b1)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[2]), .w_addr(w_addr[2]), .w_data(w_data[2]), .out_valid(out_valid[2]),
    .out_data(out_data[2]), .out_ready(out_ready), .busy(busy[2])
  );

  neuron_mac #(.NUM_INPUTS(1), .BIAS(32'h0001_0000), .RELU(1'b0)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[3]), .w_addr(w_addr[3]), .w_data(w_data[3]), .out_valid(out_valid[3]),
    .out_data(out_data[3]), .out_ready(out_ready), .busy(busy[3])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Results pop on a handshake; a stalled output must not change
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (out_valid[d] && !out_ready) begin
        if (stalled[d]) checkOutput("hold_stable", out_data[d], held[d]);
        else begin
          held[d]    = out_data[d];
          stalled[d] = 1'b1;
        end
      end else begin
        stalled[d] = 1'b0;
      end
      if (out_valid[d] && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: dut %0d gave %h with nothing expected", d, out_data[d]);
        end else begin
          e = sb.pop_front();
          checkOutput("result_dut", 32'(d), 32'(e.dut));
          checkOutput("result", out_data[d], e.val);
        end
      end
    end
  end

  task automatic applyStimulus(input int sel, input int n, input logic [31:0] exp_val,
                               input bit gaps, input bit poke);
    int k;
    int budget;
    k      = 0;
    budget = 0;
    sb.push_back('{sel, exp_val});
    start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    while (k < n && budget < 4*n + 50) begin
      in_valid   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data    = din[k];
      start[sel] = poke && (k == 2);
      @(negedge clk);
      if (in_valid && in_ready[sel]) begin
        if (n <= 4) checkOutput("w_addr", w_addr[sel], 32'(k));
        k++;
      end
      @(posedge clk); #1;
      budget++;
    end
    in_valid   = 1'b0;
    start[sel] = 1'b0;
    if (k < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got %0d accepts expected %0d", k, n);
    end else begin
      @(negedge clk);
      checkOutput("latency_1cyc", 32'(out_valid[sel]), 32'd0);
      @(negedge clk);
      checkOutput("latency_2cyc", 32'(out_valid[sel]), 32'd1);
    end
  endtask

  task automatic waitIdle(input int sel);
    int c;
    c = 0;
    while (busy[sel] && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("idle", 32'(busy[sel]), 32'd0);
  endtask

  task automatic loadBasic();
    for (int i = 0; i < 4; i++) begin
      wa[i]  = 32'h0001_0000;
      din[i] = 32'((i + 1) << 16);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    wc        = '0;
    wd        = '0;
    for (int i = 0; i < 4; i++) begin
      wa[i] = '0;
      wb[i] = '0;
    end
    for (int i = 0; i < 784; i++) din[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready[0]), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("rst_out_data", out_data[0], 32'd0);
    checkOutput("rst_busy", 32'(busy[0]), 32'd0);
    checkOutput("rst_w_addr", w_addr[0], 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    loadBasic();
    applyStimulus(0, 4, 32'h000A_0000, 1'b0, 1'b0);
    waitIdle(0);

    for (int i = 0; i < 4; i++) begin
      wa[i]  = 32'hFFFF_0000;
      wb[i]  = 32'hFFFF_0000;
      din[i] = 32'h0001_0000;
    end
    applyStimulus(0, 4, 32'h0000_0000, 1'b0, 1'b0);
    waitIdle(0);
    applyStimulus(1, 4, 32'hFFFC_0000, 1'b0, 1'b0);
    waitIdle(1);

    for (int i = 0; i < 4; i++) begin
      wa[i]  = 32'h7FFF_FFFF;
      wb[i]  = 32'h8000_0000;
      din[i] = 32'h7FFF_FFFF;
    end
    applyStimulus(0, 4, 32'h7FFF_FFFF, 1'b0, 1'b0);
    waitIdle(0);
    applyStimulus(1, 4, 32'h8000_0000, 1'b0, 1'b0);
    waitIdle(1);

    // -3 * 0.5 = -1.5 in raw units, which must floor to -2 per term
    for (int i = 0; i < 4; i++) begin
      wb[i]  = 32'h0000_8000;
      din[i] = 32'hFFFF_FFFD;
    end
    applyStimulus(1, 4, 32'hFFFF_FFF8, 1'b0, 1'b0);
    waitIdle(1);

    wc = 32'h0000_8000;
    for (int i = 0; i < 784; i++) din[i] = 32'h0000_0003;
    applyStimulus(2, 784, 32'h0000_0310, 1'b0, 1'b0);
    waitIdle(2);

    wd     = 32'h0003_0000;
    din[0] = 32'h0002_0000;
    applyStimulus(3, 1, 32'h0007_0000, 1'b0, 1'b0);
    waitIdle(3);

    loadBasic();
    out_ready = 1'b0;
    applyStimulus(0, 4, 32'h000A_0000, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      start[0] = (c == 4);
      @(posedge clk); #1;
    end
    start[0]  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(negedge clk);
    checkOutput("start_at_handshake", 32'(busy[0]), 32'd0);
    checkOutput("valid_falls", 32'(out_valid[0]), 32'd0);
    @(posedge clk); #1;

    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    in_valid = 1'b1;
    in_data  = din[0];
    @(posedge clk); #1;
    in_data = din[1];
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("abort_in_ready", 32'(in_ready[0]), 32'd0);
    checkOutput("abort_out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("abort_out_data", out_data[0], 32'd0);
    checkOutput("abort_busy", 32'(busy[0]), 32'd0);
    checkOutput("abort_w_addr", w_addr[0], 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 4, 32'h000A_0000, 1'b0, 1'b0);
    waitIdle(0);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
